// File: rtl/axi_rr_arbiter.sv
// N-master to one-slave AXI3 arbiter: independent round-robin read/write FSMs, grant held per burst, ID = master index.
// Address issued one cycle after grant; AXI_ARB_RAW_HAZARD_EN defers reads that hit the line of an in-flight write.
module axi_rr_arbiter #(
  parameter int NUM_MST   = 3,
  parameter int ID_W      = 4,
  parameter int DATA_W    = 32,
  parameter int LINE_BITS = 5
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NUM_MST*32-1:0]          m_araddr,
  input  logic [NUM_MST*8-1:0]           m_arlen,
  input  logic [NUM_MST*3-1:0]           m_arsize,
  input  logic [NUM_MST-1:0]             m_arvalid,
  output logic [NUM_MST-1:0]             m_arready,
  output logic [DATA_W-1:0]              m_rdata,
  output logic [1:0]                     m_rresp,
  output logic                           m_rlast,
  output logic [NUM_MST-1:0]             m_rvalid,
  input  logic [NUM_MST-1:0]             m_rready,
  input  logic [NUM_MST*32-1:0]          m_awaddr,
  input  logic [NUM_MST*8-1:0]           m_awlen,
  input  logic [NUM_MST*3-1:0]           m_awsize,
  input  logic [NUM_MST-1:0]             m_awvalid,
  output logic [NUM_MST-1:0]             m_awready,
  input  logic [NUM_MST*DATA_W-1:0]      m_wdata,
  input  logic [NUM_MST*DATA_W/8-1:0]    m_wstrb,
  input  logic [NUM_MST-1:0]             m_wlast,
  input  logic [NUM_MST-1:0]             m_wvalid,
  output logic [NUM_MST-1:0]             m_wready,
  output logic [1:0]                     m_bresp,
  output logic [NUM_MST-1:0]             m_bvalid,
  input  logic [NUM_MST-1:0]             m_bready,
  output logic [ID_W-1:0]                arid,
  output logic [31:0]                    araddr,
  output logic [7:0]                     arlen,
  output logic [2:0]                     arsize,
  output logic [1:0]                     arburst,
  output logic [1:0]                     arlock,
  output logic [3:0]                     arcache,
  output logic [2:0]                     arprot,
  output logic                           arvalid,
  input  logic                           arready,
  input  logic [ID_W-1:0]                rid,
  input  logic [DATA_W-1:0]              rdata,
  input  logic [1:0]                     rresp,
  input  logic                           rlast,
  input  logic                           rvalid,
  output logic                           rready,
  output logic [ID_W-1:0]                awid,
  output logic [31:0]                    awaddr,
  output logic [7:0]                     awlen,
  output logic [2:0]                     awsize,
  output logic [1:0]                     awburst,
  output logic [1:0]                     awlock,
  output logic [3:0]                     awcache,
  output logic [2:0]                     awprot,
  output logic                           awvalid,
  input  logic                           awready,
  output logic [ID_W-1:0]                wid,
  output logic [DATA_W-1:0]              wdata,
  output logic [DATA_W/8-1:0]            wstrb,
  output logic                           wlast,
  output logic                           wvalid,
  input  logic                           wready,
  input  logic [ID_W-1:0]                bid,
  input  logic [1:0]                     bresp,
  input  logic                           bvalid,
  output logic                           bready
);
  localparam int PW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int SW = DATA_W / 8;
  typedef logic [PW-1:0] idx_t;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  idx_t g_r_q, g_r_d, rr_ptr_r_q, rr_ptr_r_d;
  idx_t g_w_q, g_w_d, rr_ptr_w_q, rr_ptr_w_d;
  logic [NUM_MST-1:0] rd_elig;
  logic [PW:0] rd_pick, wr_pick;
  logic unused_sig;

  // {found, index} of the first requester at or after ptr, wrapping at NUM_MST
  function automatic logic [PW:0] rr_pick(input logic [NUM_MST-1:0] req, input idx_t ptr);
    logic [PW:0] res;
    idx_t idx;
    res = '0;
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      idx = idx_t'((int'(ptr) + k) % NUM_MST);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic idx_t rr_next(input idx_t g);
    return (int'(g) == NUM_MST - 1) ? '0 : g + idx_t'(1);
  endfunction

`ifdef AXI_ARB_RAW_HAZARD_EN
  logic [31-LINE_BITS:0] wline_q, wline_d;

  assign wline_d = (wr_state_q == W_IDLE && wr_pick[PW])
                 ? m_awaddr[32*wr_pick[PW-1:0]+LINE_BITS +: 32-LINE_BITS] : wline_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wline_q <= '0;
    else          wline_q <= wline_d;
  end

  // a read to the line still being written waits until the write returns to idle
  always_comb begin
    rd_elig = m_arvalid;
    for (int i = 0; i < NUM_MST; i++) begin
      if (wr_state_q != W_IDLE && m_araddr[32*i+LINE_BITS +: 32-LINE_BITS] == wline_q)
        rd_elig[i] = 1'b0;
    end
  end
  assign unused_sig = ^{rid, bid};
`else
  assign rd_elig    = m_arvalid;
  assign unused_sig = ^{rid, bid, (LINE_BITS != 0)};
`endif

  assign rd_pick = rr_pick(rd_elig, rr_ptr_r_q);
  assign wr_pick = rr_pick(m_awvalid, rr_ptr_w_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      g_r_q      <= '0;
      rr_ptr_r_q <= '0;
      wr_state_q <= W_IDLE;
      g_w_q      <= '0;
      rr_ptr_w_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      g_r_q      <= g_r_d;
      rr_ptr_r_q <= rr_ptr_r_d;
      wr_state_q <= wr_state_d;
      g_w_q      <= g_w_d;
      rr_ptr_w_q <= rr_ptr_w_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    g_r_d      = g_r_q;
    rr_ptr_r_d = rr_ptr_r_q;
    arvalid    = 1'b0;
    rready     = 1'b0;
    m_arready  = '0;
    m_rvalid   = '0;
    case (rd_state_q)
      R_IDLE: if (rd_pick[PW]) begin
        g_r_d      = rd_pick[PW-1:0];
        rd_state_d = R_ADDR;
      end
      R_ADDR: begin
        arvalid          = 1'b1;
        m_arready[g_r_q] = arready;
        if (arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        m_rvalid[g_r_q] = rvalid;
        rready          = m_rready[g_r_q];
        if (rvalid && m_rready[g_r_q] && rlast) begin
          rr_ptr_r_d = rr_next(g_r_q);
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    g_w_d      = g_w_q;
    rr_ptr_w_d = rr_ptr_w_q;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    m_awready  = '0;
    m_wready   = '0;
    m_bvalid   = '0;
    case (wr_state_q)
      W_IDLE: if (wr_pick[PW]) begin
        g_w_d      = wr_pick[PW-1:0];
        wr_state_d = W_ADDR;
      end
      W_ADDR: begin
        awvalid          = 1'b1;
        m_awready[g_w_q] = awready;
        if (awready) wr_state_d = W_DATA;
      end
      W_DATA: begin
        wvalid          = m_wvalid[g_w_q];
        m_wready[g_w_q] = wready;
        if (m_wvalid[g_w_q] && wready && m_wlast[g_w_q]) wr_state_d = W_RESP;
      end
      W_RESP: begin
        bready          = m_bready[g_w_q];
        m_bvalid[g_w_q] = bvalid;
        if (bvalid && m_bready[g_w_q]) begin
          rr_ptr_w_d = rr_next(g_w_q);
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign arid    = ID_W'(g_r_q);
  assign araddr  = m_araddr[32*g_r_q +: 32];
  assign arlen   = m_arlen[8*g_r_q +: 8];
  assign arsize  = m_arsize[3*g_r_q +: 3];
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign m_rdata = rdata;
  assign m_rresp = rresp;
  assign m_rlast = rlast;

  assign awid    = ID_W'(g_w_q);
  assign awaddr  = m_awaddr[32*g_w_q +: 32];
  assign awlen   = m_awlen[8*g_w_q +: 8];
  assign awsize  = m_awsize[3*g_w_q +: 3];
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wid     = ID_W'(g_w_q);
  assign wdata   = m_wdata[DATA_W*g_w_q +: DATA_W];
  assign wstrb   = m_wstrb[SW*g_w_q +: SW];
  assign wlast   = m_wlast[g_w_q];
  assign m_bresp = bresp;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: table of single reads plus hand-written multi-cycle sequences.
module tb_axi_rr_arbiter;
  localparam int N  = 3;
  localparam int IW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic aclk = 1'b0;
  logic aresetn;
  logic [N*32-1:0] m_araddr, m_awaddr;
  logic [N*8-1:0]  m_arlen, m_awlen;
  logic [N*3-1:0]  m_arsize, m_awsize;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N-1:0]    m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp, m_bresp;
  logic            m_rlast;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [IW-1:0]   arid, awid, wid, rid, bid;
  logic [31:0]     araddr, awaddr;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize, arprot, awprot;
  logic [1:0]      arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]      arcache, awcache;
  logic            arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic            wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0]   rdata, wdata;
  logic [SW-1:0]   wstrb;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi_rr_arbiter #(.NUM_MST(N), .ID_W(IW), .DATA_W(DW), .LINE_BITS(5)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awvalid(m_awvalid),
    .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m_arvalid = '0; m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
    m_rready = '1; m_bready = '1;
    m_araddr = '0; m_arlen = '0; m_arsize = '0;
    m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_wdata = '0; m_wstrb = '0;
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    bid = '0; bresp = 2'b00; bvalid = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  // mask = requesting masters, g = hand-computed expected grant
  task automatic do_read(input logic [N-1:0] mask, input int g, input logic [31:0] addr,
                         input logic [7:0] len, input string tag);
    for (int i = 0; i < N; i++) begin
      m_araddr[32*i +: 32] = (i == g) ? addr : ~addr;
      m_arlen[8*i +: 8]    = (i == g) ? len : ~len;
      m_arsize[3*i +: 3]   = 3'd2;
    end
    m_arvalid = mask;
    @(negedge aclk);
    chk({tag, ".arvalid_req_cycle"}, 64'(arvalid), 64'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk({tag, ".arvalid"}, 64'(arvalid), 64'd1);
    chk({tag, ".arid"}, 64'(arid), 64'(g));
    chk({tag, ".araddr"}, 64'(araddr), 64'(addr));
    chk({tag, ".arlen"}, 64'(arlen), 64'(len));
    chk({tag, ".m_arready"}, 64'(m_arready), 64'd1 << g);
    @(posedge aclk); #1;
    m_arvalid = '0;
    for (int b = 0; b <= int'(len); b++) begin
      rvalid = 1'b1;
      rlast  = (b == int'(len));
      rdata  = {8'(b), 24'hA5A5A5};
      @(negedge aclk);
      chk({tag, ".m_rvalid"}, 64'(m_rvalid), 64'd1 << g);
      chk({tag, ".m_rlast"}, 64'(m_rlast), 64'(b == int'(len)));
      chk({tag, ".m_rdata"}, 64'(m_rdata), 64'({8'(b), 24'hA5A5A5}));
      chk({tag, ".rready"}, 64'(rready), 64'd1);
      @(posedge aclk); #1;
    end
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge aclk);
    chk({tag, ".idle_arvalid"}, 64'(arvalid), 64'd0);
    chk({tag, ".idle_rready"}, 64'(rready), 64'd0);
    chk({tag, ".idle_m_rvalid"}, 64'(m_rvalid), 64'd0);
    @(posedge aclk); #1;
  endtask

  task automatic do_write(input logic [N-1:0] mask, input int g, input logic [31:0] addr,
                          input logic [7:0] len, input string tag);
    for (int i = 0; i < N; i++) begin
      m_awaddr[32*i +: 32] = (i == g) ? addr : ~addr;
      m_awlen[8*i +: 8]    = (i == g) ? len : ~len;
      m_awsize[3*i +: 3]   = 3'd2;
      m_wstrb[SW*i +: SW]  = (i == g) ? 4'hF : 4'h0;
    end
    m_awvalid = mask;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk({tag, ".awvalid"}, 64'(awvalid), 64'd1);
    chk({tag, ".awid"}, 64'(awid), 64'(g));
    chk({tag, ".awaddr"}, 64'(awaddr), 64'(addr));
    chk({tag, ".awlen"}, 64'(awlen), 64'(len));
    chk({tag, ".m_awready"}, 64'(m_awready), 64'd1 << g);
    @(posedge aclk); #1;
    m_awvalid = '0;
    m_wvalid  = mask;
    for (int b = 0; b <= int'(len); b++) begin
      for (int i = 0; i < N; i++) m_wdata[DW*i +: DW] = {8'(i), 8'(b), 16'hC0DE};
      m_wlast = (b == int'(len)) ? '1 : '0;
      @(negedge aclk);
      chk({tag, ".wvalid"}, 64'(wvalid), 64'd1);
      chk({tag, ".wid"}, 64'(wid), 64'(g));
      chk({tag, ".wdata"}, 64'(wdata), 64'({8'(g), 8'(b), 16'hC0DE}));
      chk({tag, ".wstrb"}, 64'(wstrb), 64'hF);
      chk({tag, ".wlast"}, 64'(wlast), 64'(b == int'(len)));
      chk({tag, ".m_wready"}, 64'(m_wready), 64'd1 << g);
      @(posedge aclk); #1;
    end
    m_wvalid = '0; m_wlast = '0;
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge aclk);
    chk({tag, ".m_bvalid"}, 64'(m_bvalid), 64'd1 << g);
    chk({tag, ".bready"}, 64'(bready), 64'd1);
    chk({tag, ".m_bresp"}, 64'(m_bresp), 64'd0);
    @(posedge aclk); #1;
    bvalid = 1'b0;
    @(negedge aclk);
    chk({tag, ".idle_awvalid"}, 64'(awvalid), 64'd0);
    chk({tag, ".idle_bready"}, 64'(bready), 64'd0);
    @(posedge aclk); #1;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           g;
    logic [31:0]  addr;
    logic [7:0]   len;
  } rd_vec_t;

  rd_vec_t rv[4];
  int      rr_exp[4];
  logic    ok;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rv[0] = '{3'b010, 1, 32'h1FC0_0000, 8'd7};
    rv[1] = '{3'b001, 0, 32'h0000_0100, 8'd0};
    rv[2] = '{3'b100, 2, 32'h8000_0040, 8'd3};
    rv[3] = '{3'b110, 1, 32'h0000_2000, 8'd1};
    rr_exp = '{0, 1, 2, 0};

    aresetn = 1'b0;
    idle_inputs();
    #12;
    chk("rst.arvalid", 64'(arvalid), 64'd0);
    chk("rst.awvalid", 64'(awvalid), 64'd0);
    chk("rst.wvalid", 64'(wvalid), 64'd0);
    chk("rst.rready", 64'(rready), 64'd0);
    chk("rst.bready", 64'(bready), 64'd0);
    chk("rst.m_ready", 64'({m_arready, m_awready, m_wready}), 64'd0);
    chk("rst.m_valid", 64'({m_rvalid, m_bvalid}), 64'd0);
    chk("rst.ids", 64'({arid, awid, wid}), 64'd0);
    chk("rst.burst", 64'({arburst, awburst}), 64'b0101);
    @(posedge aclk); #1 aresetn = 1'b1;

    for (int v = 0; v < 4; v++) do_read(rv[v].mask, rv[v].g, rv[v].addr, rv[v].len, $sformatf("rd%0d", v));

    // round robin with every master holding arvalid from reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      m_araddr[32*i +: 32] = 32'h100 * i;
      m_arlen[8*i +: 8]    = 8'd1;
    end
    m_arvalid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int t = 0; t < 8; t++) begin
        @(negedge aclk);
        if (arvalid) begin ok = 1'b1; break; end
        @(posedge aclk); #1;
      end
      chk("rr.grant_seen", 64'(ok), 64'd1);
      chk("rr.arid", 64'(arid), 64'(rr_exp[k]));
      chk("rr.araddr", 64'(araddr), 64'(32'h100 * rr_exp[k]));
      @(posedge aclk); #1;
      for (int b = 0; b < 2; b++) begin
        rvalid = 1'b1; rlast = (b == 1);
        @(negedge aclk);
        chk("rr.m_rvalid", 64'(m_rvalid), 64'd1 << rr_exp[k]);
        chk("rr.held_arvalid", 64'(arvalid), 64'd0);
        @(posedge aclk); #1;
      end
      rvalid = 1'b0; rlast = 1'b0;
      if (k == 3) m_arvalid = '0;
    end
    @(posedge aclk); #1;

    do_write(3'b100, 2, 32'h0000_1000, 8'd3, "wr_m2");
    do_write(3'b111, 0, 32'h0000_4000, 8'd0, "wr_ptr_wrap");

    // concurrent read (m0) and write (m1)
    m_araddr[0 +: 32] = 32'h500; m_arlen[0 +: 8] = 8'd0; m_arvalid = 3'b001;
    m_awaddr[32 +: 32] = 32'h600; m_awlen[8 +: 8] = 8'd0; m_awvalid = 3'b010;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("cc.arvalid", 64'(arvalid), 64'd1);
    chk("cc.awvalid", 64'(awvalid), 64'd1);
    chk("cc.arid", 64'(arid), 64'd0);
    chk("cc.awid", 64'(awid), 64'd1);
    @(posedge aclk); #1;
    m_arvalid = '0; m_awvalid = '0;
    rvalid = 1'b1; rlast = 1'b1; m_wvalid = 3'b010; m_wlast = 3'b010;
    @(negedge aclk);
    chk("cc.m_rvalid", 64'(m_rvalid), 64'b001);
    chk("cc.wvalid", 64'(wvalid), 64'd1);
    chk("cc.wid", 64'(wid), 64'd1);
    @(posedge aclk); #1;
    rvalid = 1'b0; rlast = 1'b0; m_wvalid = '0; m_wlast = '0; bvalid = 1'b1;
    @(negedge aclk);
    chk("cc.m_bvalid", 64'(m_bvalid), 64'b010);
    chk("cc.rd_idle", 64'(arvalid), 64'd0);
    @(posedge aclk); #1;
    bvalid = 1'b0;

    // reset during beat 3 of an 8-beat read from m1
    m_araddr[32 +: 32] = 32'h700; m_arlen[8 +: 8] = 8'd7; m_arvalid = 3'b010;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    m_arvalid = '0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1;
      @(posedge aclk); #1;
    end
    rvalid = 1'b1;
    @(negedge aclk);
    chk("mrst.beat3_live", 64'(m_rvalid), 64'b010);
    aresetn = 1'b0;
    #1;
    chk("mrst.m_rvalid", 64'(m_rvalid), 64'd0);
    chk("mrst.rready", 64'(rready), 64'd0);
    chk("mrst.arvalid", 64'(arvalid), 64'd0);
    chk("mrst.other", 64'({awvalid, wvalid, bready, m_arready, m_awready, m_wready, m_bvalid}), 64'd0);
    chk("mrst.arid", 64'(arid), 64'd0);
    rvalid = 1'b0;
    @(posedge aclk); #3;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    m_araddr[0 +: 32] = 32'h800; m_arlen[0 +: 8] = 8'd0;
    m_arlen[8 +: 8] = 8'd0; m_arvalid = 3'b011;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("mrst.fresh_arvalid", 64'(arvalid), 64'd1);
    chk("mrst.fresh_arid", 64'(arid), 64'd0);
    chk("mrst.fresh_araddr", 64'(araddr), 64'h800);
    @(posedge aclk); #1;
    m_arvalid = '0; rvalid = 1'b1; rlast = 1'b1;
    @(negedge aclk);
    chk("mrst.fresh_m_rvalid", 64'(m_rvalid), 64'b001);
    @(posedge aclk); #1;
    rvalid = 1'b0; rlast = 1'b0;

    // read-after-write line hazard: m1 writes 0x2000, m0 reads 0x2004, m2 reads 0x3000
    do_reset();
    m_awaddr[32 +: 32] = 32'h2000; m_awlen[8 +: 8] = 8'd7; m_awvalid = 3'b010;
    awready = 1'b0;
    @(posedge aclk); #1;
    m_araddr[0 +: 32] = 32'h2004; m_araddr[64 +: 32] = 32'h3000;
    m_arlen = '0; m_arvalid = 3'b101;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("haz.arvalid", 64'(arvalid), 64'd1);
    chk("haz.awvalid_kept", 64'(awvalid), 64'd1);
`ifdef AXI_ARB_RAW_HAZARD_EN
    chk("haz.first_arid", 64'(arid), 64'd2);
    @(posedge aclk); #1;
    m_arvalid = 3'b001; rvalid = 1'b1; rlast = 1'b1;
    @(posedge aclk); #1;
    rvalid = 1'b0; rlast = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge aclk);
      chk("haz.m0_blocked", 64'(arvalid), 64'd0);
      @(posedge aclk); #1;
    end
    awready = 1'b1;
    @(posedge aclk); #1;
    m_awvalid = '0; m_wvalid = 3'b010;
    for (int b = 0; b < 8; b++) begin
      m_wlast = (b == 7) ? 3'b010 : 3'b000;
      @(posedge aclk); #1;
    end
    m_wvalid = '0; m_wlast = '0; bvalid = 1'b1;
    @(negedge aclk);
    chk("haz.blocked_in_resp", 64'(arvalid), 64'd0);
    @(posedge aclk); #1;
    bvalid = 1'b0;
    @(negedge aclk);
    chk("haz.not_yet", 64'(arvalid), 64'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("haz.m0_granted", 64'(arvalid), 64'd1);
    chk("haz.m0_arid", 64'(arid), 64'd0);
`else
    chk("nohaz.first_arid", 64'(arid), 64'd0);
    chk("nohaz.araddr", 64'(araddr), 64'h2004);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
